// File: rtl/cejmu_pkg.sv
// Shared types and constants for the cejmu slot scheduler.
//   sched_state_t : scheduler FSM states
//   DATA_W        : width of each slot's output byte
//   DEF_N_SLOTS   : default number of requesters
//   DEF_DWELL_W   : default width of the dwell field
package cejmu_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEF_N_SLOTS = 4;
  localparam int unsigned DEF_DWELL_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StSwitch
  } sched_state_t;

endpackage

// File: rtl/cejmu_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches req upward starting at rr_ptr, wrapping from N_SLOTS-1 to 0.
//   req    : per-slot request vector
//   rr_ptr : slot with the highest priority this round
//   any    : at least one request is set
//   idx    : index of the first set request found
module cejmu_rr_pick
  import cejmu_pkg::*;
#(
  parameter int unsigned N_SLOTS = DEF_N_SLOTS
) (
  input  logic [N_SLOTS-1:0]         req,
  input  logic [$clog2(N_SLOTS)-1:0] rr_ptr,
  output logic                       any,
  output logic [$clog2(N_SLOTS)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N_SLOTS);
  localparam logic [IDX_W:0] NS = (IDX_W + 1)'(N_SLOTS);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    sum = '0;
    pos = '0;
    for (int k = 0; k < int'(N_SLOTS); k++) begin
      // One extra bit keeps rr_ptr + k from overflowing before the wrap.
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= NS) begin
        sum = sum - NS;
      end
      pos = sum[IDX_W-1:0];
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/cejmu_slot_sched.sv
// Round-robin scheduler sharing one 8-bit output bus among N_SLOTS requesters.
// Each grant lasts dwell+1 cycles when contended, is released early when the
// owner drops its request, and every hand-off passes through a blank SWITCH
// cycle followed by IDLE.
// Optional build macro CEJMU_MANUAL_SEL_EN adds a board-level manual override.
//   clk, rst_n  : clock, synchronous active-low reset
//   req         : per-slot level request
//   slot_data   : packed slot bytes, slot i at [8i+7:8i]
//   dwell       : grant length minus one, sampled when a grant is loaded
//   manual      : (macro only) override enable
//   manual_sel  : (macro only) slot forced while manual is set
//   grant       : registered one-hot grant
//   slot_id     : index of the granted slot, valid while grant != 0
//   out_data    : registered bus byte, one cycle behind slot_data[cur]
//   out_valid   : out_data carries granted slot data
module cejmu_slot_sched
  import cejmu_pkg::*;
#(
  parameter int unsigned N_SLOTS = DEF_N_SLOTS,
  parameter int unsigned DWELL_W = DEF_DWELL_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SLOTS-1:0]          req,
  input  logic [N_SLOTS*DATA_W-1:0]   slot_data,
  input  logic [DWELL_W-1:0]          dwell,
`ifdef CEJMU_MANUAL_SEL_EN
  input  logic                        manual,
  input  logic [$clog2(N_SLOTS)-1:0]  manual_sel,
`endif
  output logic [N_SLOTS-1:0]          grant,
  output logic [$clog2(N_SLOTS)-1:0]  slot_id,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid
);

  localparam int unsigned IDX_W = $clog2(N_SLOTS);
  localparam logic [IDX_W:0] NS = (IDX_W + 1)'(N_SLOTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SLOTS - 1);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  // Current grant was made by the manual override (does not move rr_ptr).
  logic               man_q, man_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_SLOTS-1:0] cur_oh, cur_d_oh;
  logic               others;

  logic               man_on;
  logic               man_valid;
  logic [IDX_W-1:0]   man_idx;

  logic [DATA_W-1:0]  slot_arr [N_SLOTS];

`ifdef CEJMU_MANUAL_SEL_EN
  assign man_on    = manual;
  assign man_valid = ({1'b0, manual_sel} < NS);
  assign man_idx   = manual_sel;
`else
  assign man_on    = 1'b0;
  assign man_valid = 1'b0;
  assign man_idx   = '0;
`endif

  for (genvar i = 0; i < int'(N_SLOTS); i++) begin : g_slot
    assign slot_arr[i] = slot_data[i*DATA_W +: DATA_W];
  end

  cejmu_rr_pick #(
    .N_SLOTS (N_SLOTS)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign cur_oh   = {{(N_SLOTS-1){1'b0}}, 1'b1} << cur_q;
  assign cur_d_oh = {{(N_SLOTS-1){1'b0}}, 1'b1} << cur_d;
  assign others   = |(req & ~cur_oh);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    man_d    = man_q;
    unique case (state_q)
      StIdle: begin
        if (man_on) begin
          // An out-of-range manual slot parks the block in IDLE.
          if (man_valid) begin
            state_d = StGrant;
            cur_d   = man_idx;
            man_d   = 1'b1;
          end
        end else if (pick_any) begin
          state_d = StGrant;
          cur_d   = pick_idx;
          cnt_d   = dwell;
          man_d   = 1'b0;
        end
      end
      StGrant: begin
        if (man_q) begin
          if (!man_on || (man_idx != cur_q)) begin
            state_d = StSwitch;
          end
        end else if (man_on) begin
          state_d = StSwitch;
        end else if (!req[cur_q]) begin
          state_d = StSwitch;
        end else if (cnt_q == '0) begin
          if (others) begin
            state_d = StSwitch;
          end else begin
            // Sole requester keeps the bus without a blanking gap.
            cnt_d = dwell;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSwitch: begin
        state_d = StIdle;
        if (!man_q) begin
          rr_ptr_d = (cur_q == LAST) ? '0 : cur_q + 1'b1;
        end
        man_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      man_q     <= 1'b0;
      grant     <= '0;
      slot_id   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      man_q    <= man_d;
      grant    <= (state_d == StGrant) ? cur_d_oh : '0;
      if (state_d == StGrant) begin
        slot_id <= cur_d;
      end
      // Data path follows the registered state, so it trails grant by a cycle.
      if (state_q == StGrant) begin
        out_data  <= slot_arr[cur_q];
        out_valid <= 1'b1;
      end else begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
